clasificador_pulsador: RTL and testbench
========================================

CLASIFICADOR_PULSADOR -- requirements
Module: clasificador_pulsador

Interface
REQ-001 Parameter T_LARGO, default 12000000: hold length in clk cycles for a long press (1 s at 12 MHz); legal range 2 to 2^32-1.
REQ-002 Parameter T_REPETICION, default 2400000: auto-repeat period in clk cycles (200 ms at 12 MHz); legal range 2 to 2^32-1.
REQ-003 Parameter HAB_REPETICION, default 1: 1 enables auto-repeat, 0 disables it.
REQ-004 clk  input  1  single system clock (12 MHz); all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn_clean  input  1  debounced button level from the debounce stage; 1 = pressed; already synchronous to clk.
REQ-007 presionado  output  1  level; 1 while the FSM is in any state other than REPOSO.
REQ-008 pulso_presion  output  1  one-cycle pulse on each accepted press.
REQ-009 pulso_corto  output  1  one-cycle pulse on release of a press held shorter than T_LARGO.
REQ-010 pulso_largo  output  1  one-cycle pulse when a hold reaches T_LARGO.
REQ-011 pulso_repeticion  output  1  one-cycle pulse every T_REPETICION cycles after pulso_largo while still held.

Function
REQ-012 All outputs SHALL be registered; there SHALL be no combinational path from btn_clean to any output.
REQ-013 The block SHALL keep a registered copy btn_prev of btn_clean. A press edge is btn_clean=1 with btn_prev=0. A release edge is btn_clean=0 with btn_prev=1.
REQ-014 The FSM SHALL have exactly three states: REPOSO, PRESIONADO and MANTENIDO. It SHALL use a single 32-bit cycle counter.
REQ-015 In REPOSO, a press edge SHALL cause three things at the same rising edge: pulso_presion goes to 1, the counter goes to 0, and the state goes to PRESIONADO.
REQ-016 In PRESIONADO with btn_clean=1, the counter SHALL increment by 1 per cycle.
REQ-017 In PRESIONADO with btn_clean=1 and counter = T_LARGO-1, the block SHALL pulse pulso_largo, clear the counter and move to MANTENIDO.
REQ-018 In PRESIONADO with btn_clean=0, the block SHALL pulse pulso_corto and return to REPOSO.
REQ-019 Simultaneous events: if release and counter = T_LARGO-1 occur in the same cycle, release SHALL win. The block pulses pulso_corto only, with no pulso_largo.
REQ-020 In MANTENIDO with HAB_REPETICION=1 and btn_clean=1, the counter SHALL increment each cycle. At counter = T_REPETICION-1 the block SHALL pulse pulso_repeticion and clear the counter.
REQ-021 In MANTENIDO with HAB_REPETICION=0, the counter SHALL hold and no repeat pulse SHALL be emitted.
REQ-022 In MANTENIDO with btn_clean=0, the block SHALL return to REPOSO with no pulso_corto; release wins over a coinciding repeat terminal count.
REQ-023 At most one of the four pulse outputs SHALL be 1 in any cycle, and each pulse SHALL last exactly one cycle.
REQ-024 presionado SHALL be 1 exactly in the cycles where the registered state is PRESIONADO or MANTENIDO.
REQ-025 The counter SHALL never wrap: its terminal compare always clears it before 2^32-1.
REQ-026 Any unreachable state encoding SHALL go to REPOSO on the next clock.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL set: state = REPOSO, counter = 0, all outputs = 0, btn_prev = 1.
REQ-028 Because btn_prev resets to 1, a button held through reset deassertion SHALL generate no event until it is released and pressed again.
REQ-029 Reset asserted in the middle of a press or hold SHALL abort it silently, with no pulso_corto.
REQ-030 rst SHALL take priority over every other condition.

Structure
REQ-031 A shared package/header SHALL hold the state encodings (REPOSO=2'd0, PRESIONADO=2'd1, MANTENIDO=2'd2), the counter width of 32, and the default timing constants for 12 MHz.
REQ-032 Edge detection SHALL live in one sub-module, detector_flanco: inputs clk, rst and d; outputs subida and bajada; reset value of the internal register is a parameter.
REQ-033 The FSM and counter SHALL live in clasificador_pulsador.

Verification (T_LARGO=10, T_REPETICION=4, HAB_REPETICION=1 unless stated)
REQ-034 Short press: btn_clean high for 5 cycles, then low. Required: pulso_presion once at the press; pulso_corto once at the release; no pulso_largo; presionado high for 5 cycles.
REQ-035 Long hold: btn_clean high for 25 cycles. Required: pulso_largo 10 cycles after pulso_presion; pulso_repeticion at +4, +8, +12 after pulso_largo; no pulso_corto on release.
REQ-036 Simultaneous release: btn_clean high for exactly 10 cycles, so release coincides with counter=9. Required: pulso_corto only.
REQ-037 Held through reset: btn_clean=1 while rst is asserted and deasserted, held for 20 more cycles. Required: no pulses. After release and one new press: pulso_presion.
REQ-038 Reset mid-hold: rst asserted 12 cycles into a press. Required: all outputs 0 on the next cycle and no pulso_corto on the later release.
REQ-039 HAB_REPETICION=0 with a 30-cycle hold. Required: one pulso_largo and zero pulso_repeticion.

Source files
------------

// File: rtl/clasificador_pulsador_pkg.sv
// Shared definitions for the push-button classifier: FSM state encodings,
// counter width and the default timing constants for a 12 MHz clock.
package clasificador_pulsador_pkg;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        PRESIONADO = 2'd1,
        MANTENIDO  = 2'd2
    } estado_t;

    localparam int CNT_W = 32;

    // 1 s long-press threshold and 200 ms auto-repeat period at 12 MHz
    localparam logic [CNT_W-1:0] T_LARGO_12MHZ      = 32'd12_000_000;
    localparam logic [CNT_W-1:0] T_REPETICION_12MHZ = 32'd2_400_000;
    localparam bit               HAB_REPETICION_DEF = 1'b1;

    // True on the last cycle of a period of 'periodo' cycles counted from 0
    function automatic logic es_terminal(input logic [CNT_W-1:0] cnt,
                                         input logic [CNT_W-1:0] periodo);
        return cnt == (periodo - 32'd1);
    endfunction

endpackage

// File: rtl/clasificador_pulsador_if.sv
// Button level in, classification level and pulses out.
// master: the side that drives the button level (debounce stage / bench).
// slave:  the classifier itself.
interface clasificador_pulsador_if;

    logic btn_clean;
    logic presionado;
    logic pulso_presion;
    logic pulso_corto;
    logic pulso_largo;
    logic pulso_repeticion;

    modport master (
        output btn_clean,
        input  presionado,
        input  pulso_presion,
        input  pulso_corto,
        input  pulso_largo,
        input  pulso_repeticion
    );

    modport slave (
        input  btn_clean,
        output presionado,
        output pulso_presion,
        output pulso_corto,
        output pulso_largo,
        output pulso_repeticion
    );

endinterface

// File: rtl/clasificador_pulsador_detector_flanco.sv
// Rise/fall detector on a signal already synchronous to clk. The reset value
// of the history register is a parameter so the owner can decide whether a
// level present at reset release counts as an edge.
module detector_flanco #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic subida,
    output logic bajada
);

    logic d_prev_reg;

    // One-cycle history of d
    always_ff @(posedge clk) begin
        if (rst) begin
            d_prev_reg <= RST_VAL;
        end else begin
            d_prev_reg <= d;
        end
    end

    assign subida = d & ~d_prev_reg;
    assign bajada = ~d & d_prev_reg;

endmodule

// File: rtl/clasificador_pulsador.sv
// Push-button classifier: turns a debounced button level into press, short,
// long and auto-repeat pulses. A single 32-bit counter times both the
// long-press threshold and the repeat period; every output is a register.
module clasificador_pulsador
    import clasificador_pulsador_pkg::*;
#(
    parameter logic [CNT_W-1:0] T_LARGO        = T_LARGO_12MHZ,
    parameter logic [CNT_W-1:0] T_REPETICION   = T_REPETICION_12MHZ,
    parameter bit               HAB_REPETICION = HAB_REPETICION_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    clasificador_pulsador_if.slave  pul
);

    estado_t          state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             presionado_reg;
    logic             pulso_presion_reg;
    logic             pulso_corto_reg;
    logic             pulso_largo_reg;
    logic             pulso_repeticion_reg;

    logic subida;
    logic bajada;
    logic soltado;

    // History resets to 1 so a button held across reset release is not
    // mistaken for a fresh press; it must be released and pressed again.
    detector_flanco #(
        .RST_VAL (1'b1)
    ) u_flanco (
        .clk    (clk),
        .rst    (rst),
        .d      (pul.btn_clean),
        .subida (subida),
        .bajada (bajada)
    );

    // In the held states the history is always 1, so bajada alone marks the
    // release; the level term keeps a held state from lingering if the
    // history were ever out of step with the state.
    assign soltado = bajada | ~pul.btn_clean;

    // Classification FSM with counter and registered outputs. Release is
    // tested before the terminal counts so it wins when both coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg            <= REPOSO;
            cnt_reg              <= '0;
            presionado_reg       <= 1'b0;
            pulso_presion_reg    <= 1'b0;
            pulso_corto_reg      <= 1'b0;
            pulso_largo_reg      <= 1'b0;
            pulso_repeticion_reg <= 1'b0;
        end else begin
            pulso_presion_reg    <= 1'b0;
            pulso_corto_reg      <= 1'b0;
            pulso_largo_reg      <= 1'b0;
            pulso_repeticion_reg <= 1'b0;

            case (state_reg)
                REPOSO: begin
                    if (subida) begin
                        pulso_presion_reg <= 1'b1;
                        cnt_reg           <= '0;
                        state_reg         <= PRESIONADO;
                        presionado_reg    <= 1'b1;
                    end else begin
                        presionado_reg    <= 1'b0;
                    end
                end

                PRESIONADO: begin
                    if (soltado) begin
                        pulso_corto_reg <= 1'b1;
                        cnt_reg         <= '0;
                        state_reg       <= REPOSO;
                        presionado_reg  <= 1'b0;
                    end else if (es_terminal(cnt_reg, T_LARGO)) begin
                        pulso_largo_reg <= 1'b1;
                        cnt_reg         <= '0;
                        state_reg       <= MANTENIDO;
                        presionado_reg  <= 1'b1;
                    end else begin
                        cnt_reg         <= cnt_reg + 32'd1;
                        presionado_reg  <= 1'b1;
                    end
                end

                MANTENIDO: begin
                    if (soltado) begin
                        cnt_reg        <= '0;
                        state_reg      <= REPOSO;
                        presionado_reg <= 1'b0;
                    end else begin
                        presionado_reg <= 1'b1;
                        if (HAB_REPETICION) begin
                            if (es_terminal(cnt_reg, T_REPETICION)) begin
                                pulso_repeticion_reg <= 1'b1;
                                cnt_reg              <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + 32'd1;
                            end
                        end
                    end
                end

                default: begin
                    state_reg      <= REPOSO;
                    cnt_reg        <= '0;
                    presionado_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pul.presionado       = presionado_reg;
    assign pul.pulso_presion    = pulso_presion_reg;
    assign pul.pulso_corto      = pulso_corto_reg;
    assign pul.pulso_largo      = pulso_largo_reg;
    assign pul.pulso_repeticion = pulso_repeticion_reg;

endmodule

// File: tb/tb_clasificador_pulsador.sv
// Directed bench for the push-button classifier. Two instances share the
// button: one with auto-repeat enabled, one with it disabled.
module tb_clasificador_pulsador;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clasificador_pulsador_if bus_rep ();
    clasificador_pulsador_if bus_norep ();

    assign bus_rep.btn_clean   = btn;
    assign bus_norep.btn_clean = btn;

    clasificador_pulsador #(
        .T_LARGO        (32'd10),
        .T_REPETICION   (32'd4),
        .HAB_REPETICION (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pul (bus_rep)
    );

    clasificador_pulsador #(
        .T_LARGO        (32'd10),
        .T_REPETICION   (32'd4),
        .HAB_REPETICION (1'b0)
    ) dut_norep (
        .clk (clk),
        .rst (rst),
        .pul (bus_norep)
    );

    // ---------------- monitor ----------------
    int cyc = 0;
    int n_pre [2];
    int n_cor [2];
    int n_lar [2];
    int n_rep [2];
    int n_hi  [2];
    int n_bad [2];
    int t_pre = 0;
    int t_lar = 0;
    int rep_t [$];
    logic [3:0] pv0, pv1;
    logic [3:0] pprev0 = 4'b0;
    logic [3:0] pprev1 = 4'b0;

    assign pv0 = {bus_rep.pulso_presion, bus_rep.pulso_corto,
                  bus_rep.pulso_largo, bus_rep.pulso_repeticion};
    assign pv1 = {bus_norep.pulso_presion, bus_norep.pulso_corto,
                  bus_norep.pulso_largo, bus_norep.pulso_repeticion};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pv0[3]) begin n_pre[0]++; t_pre = cyc; end
        if (pv0[2]) n_cor[0]++;
        if (pv0[1]) begin n_lar[0]++; t_lar = cyc; end
        if (pv0[0]) begin n_rep[0]++; rep_t.push_back(cyc); end
        if (bus_rep.presionado) n_hi[0]++;
        if ($countones(pv0) > 1 || (pv0 & pprev0) != 4'b0) n_bad[0]++;
        pprev0 = pv0;

        if (pv1[3]) n_pre[1]++;
        if (pv1[2]) n_cor[1]++;
        if (pv1[1]) n_lar[1]++;
        if (pv1[0]) n_rep[1]++;
        if (bus_norep.presionado) n_hi[1]++;
        if ($countones(pv1) > 1 || (pv1 & pprev1) != 4'b0) n_bad[1]++;
        pprev1 = pv1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Button high for exactly n rising edges, then low
    task automatic press(input int n);
        @(negedge clk);
        btn = 1'b1;
        repeat (n) @(negedge clk);
        btn = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        btn = 1'b0;
        idle(3);
        n_cmp++;
        if (bus_rep.presionado !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_presionado: got %b want 0", bus_rep.presionado);
        end
        n_cmp++;
        if (pv0 !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulsos: got %b want 0000", pv0);
        end
        n_cmp++;
        if ({bus_norep.presionado, pv1} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_norep: got %b want 00000", {bus_norep.presionado, pv1});
        end
        rst = 1'b0;
        idle(3);
        n_cmp++;
        if (n_pre[0] !== 0 || n_cor[0] !== 0) begin
            n_fail++;
            $display("FAIL reset_idle_events: got pre=%0d cor=%0d want 0/0", n_pre[0], n_cor[0]);
        end
        $display("test_reset done");
    endtask

    task automatic test_short();
        int p0, c0, l0, r0, h0;
        p0 = n_pre[0]; c0 = n_cor[0]; l0 = n_lar[0]; r0 = n_rep[0]; h0 = n_hi[0];
        press(5);
        idle(4);
        n_cmp++;
        if (n_pre[0] - p0 !== 1) begin
            n_fail++;
            $display("FAIL short_presion: got %0d want 1", n_pre[0] - p0);
        end
        n_cmp++;
        if (n_cor[0] - c0 !== 1) begin
            n_fail++;
            $display("FAIL short_corto: got %0d want 1", n_cor[0] - c0);
        end
        n_cmp++;
        if (n_lar[0] - l0 !== 0 || n_rep[0] - r0 !== 0) begin
            n_fail++;
            $display("FAIL short_no_largo: got largo=%0d rep=%0d want 0/0",
                     n_lar[0] - l0, n_rep[0] - r0);
        end
        n_cmp++;
        if (n_hi[0] - h0 !== 5) begin
            n_fail++;
            $display("FAIL short_presionado_cycles: got %0d want 5", n_hi[0] - h0);
        end
        $display("test_short done");
    endtask

    task automatic test_long();
        int c0, l0, r0, q0;
        c0 = n_cor[0]; l0 = n_lar[0]; r0 = n_rep[0]; q0 = rep_t.size();
        press(25);
        idle(4);
        n_cmp++;
        if (n_lar[0] - l0 !== 1) begin
            n_fail++;
            $display("FAIL long_largo_count: got %0d want 1", n_lar[0] - l0);
        end
        n_cmp++;
        if (t_lar - t_pre !== 10) begin
            n_fail++;
            $display("FAIL long_largo_delay: got %0d want 10", t_lar - t_pre);
        end
        n_cmp++;
        if (n_rep[0] - r0 !== 3) begin
            n_fail++;
            $display("FAIL long_rep_count: got %0d want 3", n_rep[0] - r0);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rep_t.size() < q0 + i + 1) begin
                n_fail++;
                $display("FAIL long_rep_%0d: missing, want offset %0d", i, 4 * (i + 1));
            end else if (rep_t[q0 + i] - t_lar !== 4 * (i + 1)) begin
                n_fail++;
                $display("FAIL long_rep_%0d: got offset %0d want %0d",
                         i, rep_t[q0 + i] - t_lar, 4 * (i + 1));
            end
        end
        n_cmp++;
        if (n_cor[0] - c0 !== 0) begin
            n_fail++;
            $display("FAIL long_no_corto: got %0d want 0", n_cor[0] - c0);
        end
        $display("test_long done");
    endtask

    task automatic test_simultaneous();
        int c0, l0, r0;
        c0 = n_cor[0]; l0 = n_lar[0]; r0 = n_rep[0];
        press(10);
        idle(4);
        n_cmp++;
        if (n_cor[0] - c0 !== 1) begin
            n_fail++;
            $display("FAIL simul_corto: got %0d want 1", n_cor[0] - c0);
        end
        n_cmp++;
        if (n_lar[0] - l0 !== 0 || n_rep[0] - r0 !== 0) begin
            n_fail++;
            $display("FAIL simul_no_largo: got largo=%0d rep=%0d want 0/0",
                     n_lar[0] - l0, n_rep[0] - r0);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_held_reset();
        int p0, c0, l0, r0, h0;
        @(negedge clk);
        btn = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        p0 = n_pre[0]; c0 = n_cor[0]; l0 = n_lar[0]; r0 = n_rep[0]; h0 = n_hi[0];
        idle(20);
        btn = 1'b0;
        idle(3);
        n_cmp++;
        if (n_pre[0] - p0 + n_cor[0] - c0 + n_lar[0] - l0 + n_rep[0] - r0 !== 0) begin
            n_fail++;
            $display("FAIL held_reset_no_pulses: got pre=%0d cor=%0d lar=%0d rep=%0d want all 0",
                     n_pre[0] - p0, n_cor[0] - c0, n_lar[0] - l0, n_rep[0] - r0);
        end
        n_cmp++;
        if (n_hi[0] - h0 !== 0) begin
            n_fail++;
            $display("FAIL held_reset_presionado: got %0d cycles want 0", n_hi[0] - h0);
        end
        p0 = n_pre[0];
        press(3);
        idle(3);
        n_cmp++;
        if (n_pre[0] - p0 !== 1) begin
            n_fail++;
            $display("FAIL held_reset_new_press: got %0d want 1", n_pre[0] - p0);
        end
        $display("test_held_reset done");
    endtask

    task automatic test_reset_mid_hold();
        int p0, c0, l0;
        p0 = n_pre[0]; c0 = n_cor[0]; l0 = n_lar[0];
        @(negedge clk);
        btn = 1'b1;
        idle(12);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus_rep.presionado, pv0} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b want 00000", {bus_rep.presionado, pv0});
        end
        rst = 1'b0;
        idle(3);
        btn = 1'b0;
        idle(4);
        n_cmp++;
        if (n_cor[0] - c0 !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_corto: got %0d want 0", n_cor[0] - c0);
        end
        n_cmp++;
        if (n_pre[0] - p0 !== 1 || n_lar[0] - l0 !== 1) begin
            n_fail++;
            $display("FAIL mid_reset_history: got pre=%0d lar=%0d want 1/1",
                     n_pre[0] - p0, n_lar[0] - l0);
        end
        $display("test_reset_mid_hold done");
    endtask

    task automatic test_no_repeat();
        int c0, l0, r0;
        c0 = n_cor[1]; l0 = n_lar[1]; r0 = n_rep[1];
        press(30);
        idle(4);
        n_cmp++;
        if (n_lar[1] - l0 !== 1) begin
            n_fail++;
            $display("FAIL norep_largo: got %0d want 1", n_lar[1] - l0);
        end
        n_cmp++;
        if (n_rep[1] - r0 !== 0) begin
            n_fail++;
            $display("FAIL norep_repeticion: got %0d want 0", n_rep[1] - r0);
        end
        n_cmp++;
        if (n_cor[1] - c0 !== 0) begin
            n_fail++;
            $display("FAIL norep_no_corto: got %0d want 0", n_cor[1] - c0);
        end
        $display("test_no_repeat done");
    endtask

    task automatic test_pulse_shape();
        n_cmp++;
        if (n_bad[0] + n_bad[1] !== 0) begin
            n_fail++;
            $display("FAIL pulse_shape: got %0d bad cycles want 0", n_bad[0] + n_bad[1]);
        end
        $display("test_pulse_shape done");
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_simultaneous();
        test_held_reset();
        test_reset_mid_hold();
        test_no_repeat();
        test_pulse_shape();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Safety bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
